// File: rtl/anode_scan_pkg.sv
// rtl/anode_scan_pkg.sv - shared types and constants for the seven-segment anode scanner
package anode_scan_pkg;

    typedef enum logic [1:0] {
        PRIME    = 2'd0,
        GUARD_PH = 2'd1,
        ON_PH    = 2'd2
    } scan_state_t;

    localparam int         DIGIT_COUNT = 4;
    localparam logic [3:0] AN_OFF      = 4'b1111;

    // Leading-zero blanking mask: a digit is suppressed when it and every higher digit are zero.
    // Digit 0 is never suppressed so an all-zero value still shows a single "0".
    function automatic logic [3:0] lz_mask(input logic [15:0] v);
        logic [3:0] m;
        m[3] = (v[15:12] == 4'h0);
        m[2] = m[3] && (v[11:8] == 4'h0);
        m[1] = m[2] && (v[7:4] == 4'h0);
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - per-slot cycle counter producing guard_end and slot_end strobes
module scan_prescaler #(
    parameter int TICK_DIV = 100000,
    parameter int GUARD    = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic guard_end,
    output logic slot_end
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count;

    // Strobes fire in the last cycle of each phase so the FSM switches on the following edge.
    assign slot_end  = run && (count == CW'(TICK_DIV - 1));
    assign guard_end = run && (count == CW'(GUARD - 1));

    // Slot counter: held at zero while idle, wraps to zero at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || slot_end) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/anode_scan_mux.sv
// rtl/anode_scan_mux.sv - four-digit anode scanner with per-frame latch and guard interval (option: LZ_BLANK_EN)
module anode_scan_mux
    import anode_scan_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int GUARD    = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  blank,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic [1:0]  digit_sel,
    output logic        frame_done
);

    scan_state_t state;
    logic [15:0] shadow_value;
    logic [3:0]  shadow_blank;
    logic [3:0]  lz_blank;
    logic [3:0]  lz_in;
    logic [3:0]  eff_blank;
    logic [1:0]  next_sel;
    logic        guard_end;
    logic        slot_end;

`ifdef LZ_BLANK_EN
    assign lz_in = lz_mask(value);
`else
    assign lz_in = 4'b0000;
`endif

    assign eff_blank = shadow_blank | lz_blank;
    assign next_sel  = digit_sel + 2'd1;

    scan_prescaler #(
        .TICK_DIV (TICK_DIV),
        .GUARD    (GUARD)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (state != PRIME),
        .guard_end (guard_end),
        .slot_end  (slot_end)
    );

    // Scan FSM: frame latch, digit advance and registered anode/nibble outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= PRIME;
            shadow_value <= 16'h0000;
            shadow_blank <= 4'b0000;
            lz_blank     <= 4'b0000;
            digit_sel    <= 2'd0;
            nibble       <= 4'h0;
            an           <= AN_OFF;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                PRIME: begin
                    shadow_value <= value;
                    shadow_blank <= blank;
                    lz_blank     <= lz_in;
                    digit_sel    <= 2'd0;
                    nibble       <= value[3:0];
                    an           <= AN_OFF;
                    state        <= GUARD_PH;
                end
                GUARD_PH: begin
                    if (guard_end) begin
                        state <= ON_PH;
                        an    <= eff_blank[digit_sel] ? AN_OFF : ~(4'b0001 << digit_sel);
                    end
                end
                ON_PH: begin
                    if (slot_end) begin
                        state     <= GUARD_PH;
                        an        <= AN_OFF;
                        digit_sel <= next_sel;
                        if (digit_sel == 2'(DIGIT_COUNT - 1)) begin
                            // Frame latch: digit 0 takes the fresh value on the same edge.
                            shadow_value <= value;
                            shadow_blank <= blank;
                            lz_blank     <= lz_in;
                            nibble       <= value[3:0];
                            frame_done   <= 1'b1;
                        end else begin
                            nibble <= shadow_value[{next_sel, 2'b00} +: 4];
                        end
                    end
                end
                default: begin
                    state <= PRIME;
                    an    <= AN_OFF;
                end
            endcase
        end
    end

endmodule
